// File: rtl/vbl_pkg.sv
// Shared definitions for the vertex buffer loader: FSM state encoding,
// supported ROM latency range and the read-window slice helper.
package vbl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vbl_state_e;

  localparam int unsigned ROM_LAT_MIN = 1;
  localparam int unsigned ROM_LAT_MAX = 4;

  // LSB position of window word k in the flattened read bus.
  function automatic int vbl_slice_lo(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/vbl_ram.sv
// Vertex RAM: one synchronous write port plus READ_PORTS registered read
// ports that return consecutive words starting at i_raddr (address wraps).
// Ports: clk, reset (async, active-high, clears read registers only),
//        i_we/i_waddr/i_wdata write port, i_re read enable (0 forces zero
//        data), i_raddr window base, o_rdata flattened window.
module vbl_ram
  import vbl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned READ_PORTS = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_waddr,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic                             i_re,
  input  logic [ADDR_WIDTH-1:0]            i_raddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd  [READ_PORTS];

  // Storage is deliberately not reset so partial copies survive a reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered reads see pre-write contents on a same-cycle address clash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(READ_PORTS); k++) r_rd[k] <= '0;
    end else begin
      for (int k = 0; k < int'(READ_PORTS); k++)
        r_rd[k] <= i_re ? r_mem[i_raddr + ADDR_WIDTH'(k)] : '0;
    end
  end

  for (genvar g = 0; g < int'(READ_PORTS); g++) begin : g_port
    assign o_rdata[vbl_slice_lo(g, DATA_WIDTH) +: DATA_WIDTH] = r_rd[g];
  end

endmodule

// File: rtl/vertex_buffer_loader.sv
// DMA-style loader: copies i_length words from an external synchronous ROM
// (base i_src_base) into the vertex RAM (base i_dst_base), then serves a
// READ_PORTS-word read window to the rasteriser while idle or done.
// Ports: clk, reset (async, active-high); control i_start/i_abort with
//        i_src_base/i_dst_base/i_length; ROM side o_rom_addr/i_rom_data;
//        status o_busy/o_done; read side i_read_addr/o_read_data/o_read_valid.
module vertex_buffer_loader
  import vbl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned READ_PORTS  = 9,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic [ADDR_WIDTH-1:0]            i_src_base,
  input  logic [ADDR_WIDTH-1:0]            i_dst_base,
  input  logic [ADDR_WIDTH:0]              i_length,
  output logic [ADDR_WIDTH-1:0]            o_rom_addr,
  input  logic [DATA_WIDTH-1:0]            i_rom_data,
  output logic                             o_busy,
  output logic                             o_done,
  input  logic [ADDR_WIDTH-1:0]            i_read_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] o_read_data,
  output logic                             o_read_valid
);

  localparam int unsigned LAT = (ROM_LATENCY < ROM_LAT_MIN) ? ROM_LAT_MIN :
                                (ROM_LATENCY > ROM_LAT_MAX) ? ROM_LAT_MAX :
                                ROM_LATENCY;
  localparam int unsigned CW  = ADDR_WIDTH + 1;

  vbl_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [CW-1:0]         r_len;
  logic [CW-1:0]         r_issued;
  logic [CW-1:0]         r_written;
  logic [LAT-1:0]        r_pipe;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_read_valid;

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [CW-1:0]         w_written_nxt;

  // A valid bit leaving the pipe marks ROM data present this cycle; abort kills it.
  assign w_wr_en       = r_pipe[LAT-1] && !i_abort;
  assign w_waddr       = r_dst + r_written[ADDR_WIDTH-1:0];
  assign w_written_nxt = r_written + CW'(w_wr_en);
  assign w_rd_en       = (r_state == ST_IDLE) || (r_state == ST_DONE);

  // Copy-control FSM; every cycle in ISSUE has a live ROM address, so the
  // state itself is what enters the valid pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_issued     <= '0;
      r_written    <= '0;
      r_pipe       <= '0;
      r_rom_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_read_valid <= 1'b0;
    end else begin
      r_pipe       <= LAT'({r_pipe, (r_state == ST_ISSUE)});
      r_written    <= w_written_nxt;
      r_read_valid <= w_rd_en;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end else if (i_start) begin
            r_src     <= i_src_base;
            r_dst     <= i_dst_base;
            r_len     <= i_length;
            r_written <= '0;
            if (i_length == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_ISSUE;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_rom_addr <= i_src_base;
              r_issued   <= CW'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (i_abort) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_rom_addr <= '0;
            r_pipe     <= '0;
          end else if (r_issued == r_len) begin
            r_state    <= ST_DRAIN;
            r_rom_addr <= '0;
          end else begin
            r_rom_addr <= r_src + r_issued[ADDR_WIDTH-1:0];
            r_issued   <= r_issued + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pipe  <= '0;
          end else if (w_written_nxt == r_len) begin
            // Finish on the edge of the last write, not one cycle later.
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  vbl_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .READ_PORTS (READ_PORTS)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_en),
    .i_waddr (w_waddr),
    .i_wdata (i_rom_data),
    .i_re    (w_rd_en),
    .i_raddr (i_read_addr),
    .o_rdata (o_read_data)
  );

  assign o_rom_addr   = r_rom_addr;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_read_valid = r_read_valid;

endmodule
